bram_ctl: RTL and testbench
===========================

// Module: bram_ctl
// PURPOSE
//  Dual-port byte-addressed scratch memory controller with single-cycle read/write per port.
//  Each port moves 1, 2 or 5 bytes, or a 5-byte 4-neighbour "neighbourhood", per cycle.
//  Sits between the peripheral interface and pixel/cell processing logic.
//  Supports unaligned accesses and row-width-relative neighbourhood addressing.
// PARAMETERS
//  DEPTH   256  bytes of storage; all byte addresses are taken modulo DEPTH
// PORTS
//  clk          in   1   single system clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  arraywidth   in   16  row pitch in bytes, used by NEIG mode
//  MemAddr0     in   40  port 0 byte address
//  MemDataIn0   in   40  port 0 write data
//  MemDataOut0  out  40  port 0 registered read data
//  mode0        in   2   port 0 access size: BYTE=0, HALF=1, WORD=2, NEIG=3
//  RW0          in   1   port 0: 1=read, 0=write
//  MemAddr1, MemDataIn1, MemDataOut1, mode1, RW1: same as port 0, for port 1
// BEHAVIOUR
//  Reset (rst=0, async):
//   - MemDataOut0/1 = 0.
//   - Every memory byte is cleared to 0.
//  Byte set accessed for address a (all addresses mod DEPTH; w = arraywidth):
//   - BYTE: a
//   - HALF: a, a+1
//   - WORD: a..a+4
//   - NEIG: N=a-w, W=a-1, C=a, E=a+1, S=a+w
//  Lane mapping, big-endian, first listed byte = most significant:
//   - WORD: [39:32]=a ... [7:0]=a+4
//   - HALF: [15:8]=a, [7:0]=a+1
//   - BYTE: [7:0]=a
//   - NEIG: [39:32]=N, [31:24]=W, [23:16]=C, [15:8]=E, [7:0]=S
//   - Unused read bits are 0; unused write-data bits are ignored.
//  No alignment restriction; any a is legal, and wrap past DEPTH-1 goes to 0.
//  Write (RW=0): selected bytes are updated at the rising clk edge; MemDataOut of that port holds its value.
//  Read (RW=1): MemDataOut is loaded at the rising clk edge with the bytes addressed before the edge.
//   - Latency is 1 cycle; a new access is accepted every cycle; no handshake.
//  Read sees memory before any same-edge write (read-before-write), including the other port's write.
//  Both ports writing the same byte on one edge: port 1 wins.
//  A NEIG write whose bytes alias (e.g. w=0) applies lanes in order N, W, C, E, S; the last lane wins.
//  Reset asserted mid-operation: memory and outputs clear immediately; no write completes while rst=0.
//  Implementation: byte register array (or equivalent banked RAM) giving 5 independent byte lanes per port per cycle.
// TESTING
//  1. Port 0 BYTE write a=0, data 40'hdeadbeef23; then HALF read a=0 -> MemDataOut0 = 40'h0000002300.
//  2. HALF write a=5, data 40'hdeadbeef23; then WORD read a=5 -> 40'hef23000000.
//     Then WORD read a=3 (unaligned) -> 40'h0000ef2300.
//  3. WORD write a=8, data 40'hdeadbeef23; then WORD read a=8 -> 40'hdeadbeef23.
//  4. arraywidth=6, NEIG read a=87 from cleared memory -> 0.
//     NEIG write 40'hdeadbeef23, then NEIG read a=87 -> 40'hdeadbeef23.
//     Then WORD reads: a=80 -> 40'h00de000000; a=86 -> 40'hadbeef0000; a=92 -> 40'h0023000000.
//  5. Same edge: port 0 BYTE write a=10, data 0x11; port 1 BYTE write a=10, data 0x22.
//     Next BYTE read at a=10 -> 40'h22.
//     Separately: port 1 WORD read concurrent with a port 0 write to the same bytes returns the old data.
//  6. After writes, pulse rst low mid-cycle -> outputs 0 at once; later reads of any address -> 0.
//     WORD read a=DEPTH-2 wraps to bytes DEPTH-2, DEPTH-1, 0, 1, 2.

Source files
------------

// File: rtl/bram_ctl.sv
// Dual-port byte-addressed scratch memory. Each port reads or writes 1, 2 or 5 bytes
// (or a 4-neighbour cross) per cycle, with any alignment and wrap at DEPTH.
module bram_ctl #(
    parameter int DEPTH = 256   // must be a power of two: addresses wrap by truncation
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] arraywidth,
    input  logic [39:0] MemAddr0,
    input  logic [39:0] MemDataIn0,
    output logic [39:0] MemDataOut0,
    input  logic [1:0]  mode0,
    input  logic        RW0,
    input  logic [39:0] MemAddr1,
    input  logic [39:0] MemDataIn1,
    output logic [39:0] MemDataOut1,
    input  logic [1:0]  mode1,
    input  logic        RW1
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = 5;

    typedef enum logic [1:0] {
        MODE_BYTE = 2'd0,
        MODE_HALF = 2'd1,
        MODE_WORD = 2'd2,
        MODE_NEIG = 2'd3
    } mode_e;

    logic [39:0] w_addr  [2];
    logic [1:0]  w_mode  [2];
    logic        w_rw    [2];
    logic [7:0]  r_mem   [DEPTH];
    logic        w_unused;

    assign w_addr[0] = MemAddr0;
    assign w_addr[1] = MemAddr1;
    assign w_mode[0] = mode0;
    assign w_mode[1] = mode1;
    assign w_rw[0]   = RW0;
    assign w_rw[1]   = RW1;

    // Upper address and pitch bits fall away under the modulo-DEPTH wrap.
    assign w_unused = &{1'b0, arraywidth[15:AW], MemAddr0[39:AW], MemAddr1[39:AW]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_port
            logic [AW-1:0]    w_base;
            logic [AW-1:0]    w_pitch;
            logic [AW-1:0]    w_lane_addr [LANES];
            logic [LANES-1:0] w_lane_en;
            logic [39:0]      w_rd_data;
            logic [39:0]      r_dout;

            assign w_base  = w_addr[gi][AW-1:0];
            assign w_pitch = arraywidth[AW-1:0];

            // Lane 4 is the most significant byte; lane k defaults to base+(4-k).
            always_comb begin
                for (int k = 0; k < LANES; k++) begin
                    w_lane_addr[k] = w_base + AW'(LANES - 1 - k);
                end
                w_lane_en = '0;
                case (mode_e'(w_mode[gi]))
                    MODE_BYTE: begin
                        w_lane_addr[0] = w_base;
                        w_lane_en      = 5'b00001;
                    end
                    MODE_HALF: begin
                        w_lane_addr[1] = w_base;
                        w_lane_addr[0] = w_base + AW'(1);
                        w_lane_en      = 5'b00011;
                    end
                    MODE_WORD: begin
                        w_lane_en = 5'b11111;
                    end
                    MODE_NEIG: begin
                        w_lane_addr[4] = w_base - w_pitch;
                        w_lane_addr[3] = w_base - AW'(1);
                        w_lane_addr[2] = w_base;
                        w_lane_addr[1] = w_base + AW'(1);
                        w_lane_addr[0] = w_base + w_pitch;
                        w_lane_en      = 5'b11111;
                    end
                    default: begin
                        w_lane_en = '0;
                    end
                endcase
            end

            always_comb begin
                w_rd_data = '0;
                for (int k = 0; k < LANES; k++) begin
                    if (w_lane_en[k]) begin
                        w_rd_data[8*k +: 8] = r_mem[w_lane_addr[k]];
                    end
                end
            end

            // Output only moves on a read; a write leaves the last read data in place.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dout <= '0;
                end else if (w_rw[gi]) begin
                    r_dout <= w_rd_data;
                end
            end
        end
    endgenerate

    assign MemDataOut0 = gen_port[0].r_dout;
    assign MemDataOut1 = gen_port[1].r_dout;

    // Port 0 lanes first, then port 1, each from N down to S: the later assignment wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (!RW0) begin
                for (int k = LANES - 1; k >= 0; k--) begin
                    if (gen_port[0].w_lane_en[k]) begin
                        r_mem[gen_port[0].w_lane_addr[k]] <= MemDataIn0[8*k +: 8];
                    end
                end
            end
            if (!RW1) begin
                for (int k = LANES - 1; k >= 0; k--) begin
                    if (gen_port[1].w_lane_en[k]) begin
                        r_mem[gen_port[1].w_lane_addr[k]] <= MemDataIn1[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_ctl.sv
// Directed bench for bram_ctl: stimulus pushes expected read data into per-port queues,
// a monitor pops and compares one cycle later.
module tb_bram_ctl;

    localparam logic [1:0] BYTE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] WORD = 2'd2;
    localparam logic [1:0] NEIG = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] arraywidth;
    logic [39:0] MemAddr0, MemDataIn0, MemDataOut0;
    logic [39:0] MemAddr1, MemDataIn1, MemDataOut1;
    logic [1:0]  mode0, mode1;
    logic        RW0, RW1;

    always #5 clk = ~clk;

    bram_ctl #(.DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .arraywidth (arraywidth),
        .MemAddr0   (MemAddr0),
        .MemDataIn0 (MemDataIn0),
        .MemDataOut0(MemDataOut0),
        .mode0      (mode0),
        .RW0        (RW0),
        .MemAddr1   (MemAddr1),
        .MemDataIn1 (MemDataIn1),
        .MemDataOut1(MemDataOut1),
        .mode1      (mode1),
        .RW1        (RW1)
    );

    typedef struct {
        bit          chk;
        logic [39:0] exp;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b1;
    bit          c0, c1;
    logic [39:0] e0, e1;

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic rd0(input logic [1:0] m, input logic [39:0] a, input logic [39:0] e);
        mode0 = m; RW0 = 1'b1; MemAddr0 = a; MemDataIn0 = 40'hffffffffff; c0 = 1'b1; e0 = e;
    endtask

    task automatic rd1(input logic [1:0] m, input logic [39:0] a, input logic [39:0] e);
        mode1 = m; RW1 = 1'b1; MemAddr1 = a; MemDataIn1 = 40'hffffffffff; c1 = 1'b1; e1 = e;
    endtask

    task automatic wr0(input logic [1:0] m, input logic [39:0] a, input logic [39:0] d);
        mode0 = m; RW0 = 1'b0; MemAddr0 = a; MemDataIn0 = d; c0 = 1'b0;
        $display("wr   p0 mode=%0d addr=%0d data=%h", m, a, d);
    endtask

    task automatic wr1(input logic [1:0] m, input logic [39:0] a, input logic [39:0] d);
        mode1 = m; RW1 = 1'b0; MemAddr1 = a; MemDataIn1 = d; c1 = 1'b0;
        $display("wr   p1 mode=%0d addr=%0d data=%h", m, a, d);
    endtask

    task automatic idle();
        mode0 = BYTE; RW0 = 1'b1; MemAddr0 = '0; MemDataIn0 = '0; c0 = 1'b0; e0 = '0;
        mode1 = BYTE; RW1 = 1'b1; MemAddr1 = '0; MemDataIn1 = '0; c1 = 1'b0; e1 = '0;
    endtask

    // Records what the coming edge should produce, then advances one cycle.
    task automatic step();
        if (rst && RW0) q0.push_back('{c0, e0});
        if (rst && RW1) q1.push_back('{c1, e1});
        @(posedge clk);
        #2;
        idle();
    endtask

    // Monitor: every read edge outside reset yields one output per port.
    bit   s0, s1;
    int   id0 = 0, id1 = 0;
    exp_t m0, m1;
    initial begin
        forever begin
            @(posedge clk);
            s0 = mon_en && rst && RW0;
            s1 = mon_en && rst && RW1;
            #1;
            if (s0) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL p0 unexpected read: got %h expected none", MemDataOut0);
                end else begin
                    m0 = q0.pop_front();
                    if (m0.chk) check($sformatf("p0 read %0d", id0), MemDataOut0, m0.exp);
                    id0++;
                end
            end
            if (s1) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL p1 unexpected read: got %h expected none", MemDataOut1);
                end else begin
                    m1 = q1.pop_front();
                    if (m1.chk) check($sformatf("p1 read %0d", id1), MemDataOut1, m1.exp);
                    id1++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        arraywidth = 16'd6;
        idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        check("reset out0", MemDataOut0, 40'h0);
        check("reset out1", MemDataOut1, 40'h0);
        rst = 1'b1;

        wr0(BYTE, 40'd0, 40'hdeadbeef23);                                   step();
        rd0(HALF, 40'd0, 40'h0000002300);                                   step();
        wr0(HALF, 40'd5, 40'hdeadbeef23);                                   step();
        rd0(WORD, 40'd5, 40'hef23000000); rd1(WORD, 40'd3, 40'h0000ef2300); step();
        wr0(WORD, 40'd8, 40'hdeadbeef23);                                   step();
        rd0(WORD, 40'd8, 40'hdeadbeef23);                                   step();
        arraywidth = 16'd6;
        rd1(NEIG, 40'd87, 40'h0);                                           step();
        wr1(NEIG, 40'd87, 40'hdeadbeef23);                                  step();
        rd1(NEIG, 40'd87, 40'hdeadbeef23); rd0(WORD, 40'd80, 40'h00de000000); step();
        rd0(WORD, 40'd86, 40'hadbeef0000); rd1(WORD, 40'd92, 40'h0023000000); step();
        wr0(BYTE, 40'd10, 40'h11); wr1(BYTE, 40'd10, 40'h22);               step();
        rd0(BYTE, 40'd10, 40'h22);                                          step();
        wr0(WORD, 40'd8, 40'h0102030405); rd1(WORD, 40'd8, 40'hdead22ef23); step();
        rd1(WORD, 40'd8, 40'h0102030405); rd0(HALF, 40'd12, 40'h0000000500); step();
        wr0(WORD, 40'd254, 40'ha1b2c3d4e5);                                 step();
        rd0(WORD, 40'd254, 40'ha1b2c3d4e5); rd1(BYTE, 40'd1, 40'hd4);       step();
        arraywidth = 16'd0;
        wr1(NEIG, 40'd100, 40'h1122334455);                                 step();
        rd1(WORD, 40'd99, 40'h2255440000); rd0(WORD, 40'd99, 40'h2255440000); step();
        arraywidth = 16'd300;
        rd0(NEIG, 40'd1, 40'h00c3d4e500); rd1(WORD, 40'h1200000108, 40'h0102030405); step();
        rd0(WORD, 40'd8, 40'h0102030405); rd1(BYTE, 40'd0, 40'hc3);         step();

        // Reset pulse in mid-cycle with a write pending that must never land.
        rst = 1'b0;
        wr0(BYTE, 40'd20, 40'hff);
        #1;
        check("mid-reset out0", MemDataOut0, 40'h0);
        check("mid-reset out1", MemDataOut1, 40'h0);
        step();
        rst = 1'b1;

        rd0(WORD, 40'd254, 40'h0); rd1(BYTE, 40'd20, 40'h0);                step();
        arraywidth = 16'd6;
        rd0(WORD, 40'd8, 40'h0); rd1(NEIG, 40'd87, 40'h0);                  step();
        mon_en = 1'b0;

        check("p0 queue drained", 40'(q0.size()), 40'h0);
        check("p1 queue drained", 40'(q1.size()), 40'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
